// File: rtl/mult_result_buffer_pkg.sv
// Shared constants for the multiplier (and future divider) result stages:
// default operand width, occupancy encodings and width-sized constants.
package mult_result_buffer_pkg;

  localparam int DEFAULT_WIDTH     = 4;
  localparam int DEFAULT_CNT_WIDTH = 8;

  // Occupancy of the 2-entry result FIFO; this is also the control state.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_HALF  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam logic [DEFAULT_WIDTH-1:0] ALL_ONES = {DEFAULT_WIDTH{1'b1}};
  localparam logic [DEFAULT_WIDTH-1:0] ALL_ZERO = {DEFAULT_WIDTH{1'b0}};

endpackage

// File: rtl/mult_flag_gen.sv
// Combinational status flags for a {high,low} product pair.
// zero: whole product is 0; overflow: product does not fit in the low word.
module mult_flag_gen #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] high,
  input  logic [WIDTH-1:0] low,
  output logic             zero,
  output logic             overflow
);

  // Flags are pure reductions of the incoming halves.
  always_comb begin
    zero     = ~|{high, low};
    overflow = |high;
  end

endmodule

// File: rtl/mult_result_buffer.sv
// Registered 2-entry result buffer behind the multiplier datapath.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; in_ready depends only on registered occupancy (no out_ready->in_ready
// path), and head outputs are stable while out_valid && !out_ready.
module mult_result_buffer
  import mult_result_buffer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SATURATE  = 0,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_high,
  input  logic [WIDTH-1:0]     in_low,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_high,
  output logic [WIDTH-1:0]     out_low,
  output logic [WIDTH-1:0]     sat_low,
  output logic                 flag_zero,
  output logic                 flag_overflow,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [1:0]           count
);

  localparam logic [WIDTH-1:0] SAT_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0]     high_q [2];
  logic [WIDTH-1:0]     high_d [2];
  logic [WIDTH-1:0]     low_q  [2];
  logic [WIDTH-1:0]     low_d  [2];
  logic                 zero_q [2];
  logic                 zero_d [2];
  logic                 ovf_q  [2];
  logic                 ovf_d  [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic push;
  logic pop;
  logic in_zero;
  logic in_ovf;
  logic head_ovf;

  mult_flag_gen #(
    .WIDTH(WIDTH)
  ) u_flag_gen (
    .high     (in_high),
    .low      (in_low),
    .zero     (in_zero),
    .overflow (in_ovf)
  );

  // Handshake qualifiers and head-entry presentation straight from storage.
  always_comb begin
    in_ready      = (count_q != OCC_FULL);
    out_valid     = (count_q != OCC_EMPTY);
    push          = in_valid && in_ready;
    pop           = out_valid && out_ready;
    out_high      = high_q[rd_ptr_q];
    out_low       = low_q[rd_ptr_q];
    flag_zero     = zero_q[rd_ptr_q];
    head_ovf      = ovf_q[rd_ptr_q];
    flag_overflow = head_ovf;
    sat_low       = ((SATURATE != 0) && head_ovf) ? SAT_ONES : low_q[rd_ptr_q];
    retired_count = retired_q;
    count         = count_q;
  end

  // Next-state: write the tail on push, advance pointers, track occupancy.
  always_comb begin
    high_d    = high_q;
    low_d     = low_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    count_d   = count_q;
    retired_d = retired_q;
    if (push) begin
      high_d[wr_ptr_q] = in_high;
      low_d[wr_ptr_q]  = in_low;
      zero_d[wr_ptr_q] = in_zero;
      ovf_d[wr_ptr_q]  = in_ovf;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end
  end

  // State registers; reset empties the FIFO and zeroes every stored field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        high_q[i] <= WORD_ZERO;
        low_q[i]  <= WORD_ZERO;
        zero_q[i] <= 1'b0;
        ovf_q[i]  <= 1'b0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= OCC_EMPTY;
      retired_q <= '0;
    end else begin
      high_q    <= high_d;
      low_q     <= low_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_mult_result_buffer.sv
// Bench for mult_result_buffer with WIDTH=4, SATURATE=1, CNT_WIDTH=2.
module tb_mult_result_buffer;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_high;
  logic [W-1:0]  in_low;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_high;
  logic [W-1:0]  out_low;
  logic [W-1:0]  sat_low;
  logic          flag_zero;
  logic          flag_overflow;
  logic [CW-1:0] retired_count;
  logic [1:0]    count;

  mult_result_buffer #(
    .WIDTH     (W),
    .SATURATE  (1),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_high       (in_high),
    .in_low        (in_low),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_high      (out_high),
    .out_low       (out_low),
    .sat_low       (sat_low),
    .flag_zero     (flag_zero),
    .flag_overflow (flag_overflow),
    .retired_count (retired_count),
    .count         (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];       // accepted products {high,low}, oldest first
  int             retired_total;  // products taken by the consumer since reset
  int             tests;
  int             fails;
  int             model_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of two products, updated at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      retired_total = 0;
    end else begin
      model_n = exp_q.size();
      if (model_n > 0 && out_ready) begin
        void'(exp_q.pop_front());
        retired_total++;
      end
      if (in_valid && model_n < 2) exp_q.push_back({in_high, in_low});
    end
  end

  // Monitor: compare DUT status and head entry against the model mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0] eh, el;
    if (rst_n) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() != 2));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("retired_count", 32'(retired_count), 32'(retired_total % 4));
      if (exp_q.size() > 0) begin
        eh = exp_q[0][2*W-1:W];
        el = exp_q[0][W-1:0];
        chk("out_high", 32'(out_high), 32'(eh));
        chk("out_low", 32'(out_low), 32'(el));
        chk("flag_zero", 32'(flag_zero), 32'(eh == 0 && el == 0));
        chk("flag_overflow", 32'(flag_overflow), 32'(eh != 0));
        chk("sat_low", 32'(sat_low), (eh != 0) ? 32'hF : 32'(el));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [W-1:0] h, input logic [W-1:0] l,
                       input logic r);
    in_valid  = v;
    in_high   = h;
    in_low    = l;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    in_high = '0;
    in_low  = '0;
    do_reset();

    // Reset in the middle of a stream: fill, then drop rst_n between edges.
    cycle(1'b1, 4'h1, 4'h5, 1'b0);
    cycle(1'b1, 4'h2, 4'h6, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_retired", 32'(retired_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_high", 32'(out_high), 32'd0);
    chk("rst_out_low", 32'(out_low), 32'd0);
    chk("rst_flag_zero", 32'(flag_zero), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single product 3*4 = 0x0C, then pop it.
    cycle(1'b1, 4'h0, 4'hC, 1'b0);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);
    chk("single_retired", 32'(retired_count), 32'd1);

    // Overflowing product 15*15 = 0xE1, saturated low word.
    cycle(1'b1, 4'hE, 4'h1, 1'b0);
    cycle(1'b0, 4'h0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);

    // Backpressure: two pushes fill, third offer must be ignored.
    cycle(1'b1, 4'h0, 4'h0, 1'b0);
    cycle(1'b1, 4'h1, 4'h2, 1'b0);
    cycle(1'b1, 4'h3, 4'h3, 1'b0);
    cycle(1'b1, 4'h4, 4'h4, 1'b0);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 1'b1);

    // Streaming at occupancy 1: push and pop every cycle.
    do_reset();
    cycle(1'b1, 4'h0, 4'h0, 1'b0);
    for (int i = 1; i <= 10; i++) cycle(1'b1, 4'h0, 4'(i), 1'b1);
    chk("stream_retired", 32'(retired_count), 32'(10 % 4));
    cycle(1'b0, 4'h0, 4'h0, 1'b1);

    // Counter wrap: five retirements from reset give 1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'(i), 4'(i + 1), 1'b0);
      cycle(1'b0, 4'h0, 4'h0, 1'b1);
      chk("wrap_retired", 32'(retired_count), 32'((i + 1) % 4));
    end

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 4'h0, 1'b1);
    chk("drained_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
